fp_busy_sequencer: RTL and testbench

- Consumes the Cop1 decode outputs (4-bit FP op code, 5-bit busy time) and sequences one in-flight FP operation.
- Counts the busy time down and issues a one-cycle writeback strobe.
- Raises pipeline stall for structural hazards (single FPU) and RAW hazards on the pending FP destination.
- Sits between the Cop1 decode stage and the FP register file / FCC flag writeback.

---
 rtl/fp_busy_sequencer_pkg.sv | 46 ++++
 rtl/fp_busy_sequencer_if.sv | 39 +++
 rtl/fp_hazard_cmp.sv | 21 ++
 rtl/fp_busy_sequencer.sv | 106 ++++++++++
 tb/tb_fp_busy_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_busy_sequencer_pkg.sv
// Shared Cop1 FP parameters: widths, op codes, sequencer state encoding
// and the compare-op class helper.
package fp_busy_sequencer_pkg;

  localparam int BUSY_W = 5;
  localparam int OP_W   = 4;
  localparam int REG_W  = 5;

  localparam logic [BUSY_W-1:0] BUSY_ONE = BUSY_W'(1);

  // FP op codes produced by Cop1 decode; 0 means "no / illegal op"
  localparam logic [OP_W-1:0] OPNONE  = 4'd0;
  localparam logic [OP_W-1:0] OPADDS  = 4'd1;
  localparam logic [OP_W-1:0] OPSUBS  = 4'd2;
  localparam logic [OP_W-1:0] OPMULS  = 4'd3;
  localparam logic [OP_W-1:0] OPDIVS  = 4'd4;
  localparam logic [OP_W-1:0] OPSQRT  = 4'd5;
  localparam logic [OP_W-1:0] OPABS   = 4'd6;
  localparam logic [OP_W-1:0] OPMOV   = 4'd7;
  localparam logic [OP_W-1:0] OPNEG   = 4'd8;
  localparam logic [OP_W-1:0] OPCVTSW = 4'd9;
  localparam logic [OP_W-1:0] OPCVTWS = 4'd10;
  localparam logic [OP_W-1:0] OPCEQ   = 4'd11;
  localparam logic [OP_W-1:0] OPCLT   = 4'd12;
  localparam logic [OP_W-1:0] OPCLE   = 4'd13;

  // FP sequencer state encoding
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seqState_e;

  // Compare ops retire into the FCC flag instead of a register
  localparam logic [OP_W-1:0] CMP_OPS [3] = '{OPCEQ, OPCLT, OPCLE};

  function automatic logic isCompareOp(input logic [OP_W-1:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (op == CMP_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/fp_busy_sequencer_if.sv
// Decode / writeback handshake bundle for the FP busy sequencer.
interface fp_busy_sequencer_if;
  import fp_busy_sequencer_pkg::*;

  logic              iStart;
  logic [OP_W-1:0]   iControlSignal;
  logic [BUSY_W-1:0] iFPBusyTime;
  logic [REG_W-1:0]  iFd;
  logic [REG_W-1:0]  iRs;
  logic [REG_W-1:0]  iRt;
  logic              iRsUse;
  logic              iRtUse;
  logic              iWbStall;
  logic              oStall;
  logic              oBusy;
  logic              oResultValid;
  logic              oWbRegEn;
  logic              oWbFlagEn;
  logic [REG_W-1:0]  oWbReg;
  logic [OP_W-1:0]   oOp;
  logic              oIllegal;

  // Decode / pipeline side
  modport master (
    output iStart, iControlSignal, iFPBusyTime, iFd, iRs, iRt,
           iRsUse, iRtUse, iWbStall,
    input  oStall, oBusy, oResultValid, oWbRegEn, oWbFlagEn,
           oWbReg, oOp, oIllegal
  );

  // Sequencer side
  modport slave (
    input  iStart, iControlSignal, iFPBusyTime, iFd, iRs, iRt,
           iRsUse, iRtUse, iWbStall,
    output oStall, oBusy, oResultValid, oWbRegEn, oWbFlagEn,
           oWbReg, oOp, oIllegal
  );

endinterface

// File: rtl/fp_hazard_cmp.sv
// RAW comparator: flags a decode-stage read of a pending FP register result.
module fp_hazard_cmp
  import fp_busy_sequencer_pkg::*;
(
  input  logic             pendActive,
  input  logic             pendIsReg,
  input  logic [REG_W-1:0] pendReg,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             rsUse,
  input  logic             rtUse,
  output logic             rawHazard
);

  // No forwarding: any real source read of the pending destination must wait
  always_comb begin
    rawHazard = pendActive && pendIsReg &&
                ((rsUse && (rs == pendReg)) || (rtUse && (rt == pendReg)));
  end

endmodule

// File: rtl/fp_busy_sequencer.sv
// Sequences one in-flight FP op: counts its busy time down, issues the
// writeback strobe and raises decode stall on structural and RAW hazards.
module fp_busy_sequencer
  import fp_busy_sequencer_pkg::*;
(
  input  logic                 iCLK,
  input  logic                 iRST,
  fp_busy_sequencer_if.slave   bus
);

  seqState_e         state;
  seqState_e         nextState;
  logic [BUSY_W-1:0] count;
  logic [OP_W-1:0]   opReg;
  logic [REG_W-1:0]  wbReg;
  logic              isFlag;
  logic              busy;
  logic              rawStall;
  logic              structStall;
  logic              stall;
  logic              startLegal;
  logic              accept;
  logic              resultValid;

  assign busy       = (state != SEQ_IDLE);
  assign startLegal = (bus.iControlSignal != '0) && (bus.iFPBusyTime != '0);
  assign accept     = bus.iStart && !stall && startLegal;

  fp_hazard_cmp uHazard (
    .pendActive (busy),
    .pendIsReg  (!isFlag),
    .pendReg    (wbReg),
    .rs         (bus.iRs),
    .rt         (bus.iRt),
    .rsUse      (bus.iRsUse),
    .rtUse      (bus.iRtUse),
    .rawHazard  (rawStall)
  );

  // Single FPU: a new op cannot issue while one is running or blocked at writeback
  always_comb begin
    structStall = bus.iStart &&
                  ((state == SEQ_RUN) || ((state == SEQ_DONE) && bus.iWbStall));
    stall = structStall || rawStall;
  end

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= SEQ_IDLE;
    else      state <= nextState;
  end

  // Latch the accepted op and run the busy-time countdown
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      count  <= '0;
      opReg  <= '0;
      wbReg  <= '0;
      isFlag <= 1'b0;
    end else if (accept) begin
      count  <= bus.iFPBusyTime - BUSY_ONE;
      opReg  <= bus.iControlSignal;
      wbReg  <= bus.iFd;
      isFlag <= isCompareOp(bus.iControlSignal);
    end else if (state == SEQ_RUN) begin
      count  <= count - BUSY_ONE;
    end
  end

  // Next-state: a start may load from IDLE or from a DONE cycle that retires
  always_comb begin
    nextState = state;
    case (state)
      SEQ_IDLE: begin
        if (accept)
          nextState = (bus.iFPBusyTime == BUSY_ONE) ? SEQ_DONE : SEQ_RUN;
      end
      SEQ_RUN: begin
        if (count == BUSY_ONE) nextState = SEQ_DONE;
      end
      SEQ_DONE: begin
        if (!bus.iWbStall) begin
          if (accept)
            nextState = (bus.iFPBusyTime == BUSY_ONE) ? SEQ_DONE : SEQ_RUN;
          else
            nextState = SEQ_IDLE;
        end
      end
      default: nextState = SEQ_IDLE;
    endcase
  end

  // Outputs: strobe only when the writeback port is free; illegal only when not stalled
  always_comb begin
    resultValid      = (state == SEQ_DONE) && !bus.iWbStall;
    bus.oResultValid = resultValid;
    bus.oWbRegEn     = resultValid && !isFlag;
    bus.oWbFlagEn    = resultValid && isFlag;
    bus.oBusy        = busy;
    bus.oStall       = stall;
    bus.oWbReg       = wbReg;
    bus.oOp          = opReg;
    bus.oIllegal     = bus.iStart && !stall && !startLegal;
  end

endmodule

// File: tb/tb_fp_busy_sequencer.sv
// Directed self-checking bench for fp_busy_sequencer.
module tb_fp_busy_sequencer;
  import fp_busy_sequencer_pkg::*;

  logic iCLK;
  logic iRST;
  int   assertCount;
  int   failCount;

  fp_busy_sequencer_if bus ();

  fp_busy_sequencer dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus.slave)
  );

  // 10 ns clock
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [OP_W-1:0] op,
                               input logic [BUSY_W-1:0] n, input logic [REG_W-1:0] fd,
                               input logic [REG_W-1:0] rs, input logic rsUse,
                               input logic [REG_W-1:0] rt, input logic rtUse,
                               input logic wbStall);
    bus.iStart         = start;
    bus.iControlSignal = op;
    bus.iFPBusyTime    = n;
    bus.iFd            = fd;
    bus.iRs            = rs;
    bus.iRsUse         = rsUse;
    bus.iRt            = rt;
    bus.iRtUse         = rtUse;
    bus.iWbStall       = wbStall;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, OPNONE, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // ADDS N=6 fd=4 from IDLE: strobe exactly at cycle 6, IDLE at cycle 7
  task automatic runAddScenario(input string tag);
    applyStimulus(1'b1, OPADDS, 5'd6, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput({tag, ".c0.stall"}, 32'(bus.oStall), 32'd0);
    checkOutput({tag, ".c0.busy"}, 32'(bus.oBusy), 32'd0);
    @(negedge iCLK);
    for (int c = 1; c <= 7; c++) begin
      idleCycle();
      #1;
      checkOutput($sformatf("%s.c%0d.busy", tag, c), 32'(bus.oBusy), 32'(c <= 6));
      checkOutput($sformatf("%s.c%0d.valid", tag, c), 32'(bus.oResultValid), 32'(c == 6));
      checkOutput($sformatf("%s.c%0d.regEn", tag, c), 32'(bus.oWbRegEn), 32'(c == 6));
      checkOutput($sformatf("%s.c%0d.flagEn", tag, c), 32'(bus.oWbFlagEn), 32'd0);
      if (c == 6) begin
        checkOutput({tag, ".c6.wbReg"}, 32'(bus.oWbReg), 32'd4);
        checkOutput({tag, ".c6.op"}, 32'(bus.oOp), 32'(OPADDS));
      end
      @(negedge iCLK);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    iRST = 1'b1;
    idleCycle();
    @(negedge iCLK);
    @(negedge iCLK);
    #1;
    checkOutput("rst.busy", 32'(bus.oBusy), 32'd0);
    checkOutput("rst.valid", 32'(bus.oResultValid), 32'd0);
    checkOutput("rst.wbReg", 32'(bus.oWbReg), 32'd0);
    checkOutput("rst.op", 32'(bus.oOp), 32'd0);
    checkOutput("rst.stall", 32'(bus.oStall), 32'd0);
    checkOutput("rst.illegal", 32'(bus.oIllegal), 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;

    $display("[TB] scenario 1: ADDS latency");
    runAddScenario("s1");

    $display("[TB] scenario 2: back-to-back issue in DONE");
    applyStimulus(1'b1, OPABS, 5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1; checkOutput("s2.c0.stall", 32'(bus.oStall), 32'd0);
    @(negedge iCLK);
    applyStimulus(1'b1, OPMULS, 5'd4, 5'd3, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("s2.c1.valid", 32'(bus.oResultValid), 32'd1);
    checkOutput("s2.c1.regEn", 32'(bus.oWbRegEn), 32'd1);
    checkOutput("s2.c1.wbReg", 32'(bus.oWbReg), 32'd2);
    checkOutput("s2.c1.stall", 32'(bus.oStall), 32'd0);
    @(negedge iCLK);
    applyStimulus(1'b0, OPNONE, 5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    #1;
    checkOutput("s2.c2.rtStall", 32'(bus.oStall), 32'd1);
    checkOutput("s2.c2.busy", 32'(bus.oBusy), 32'd1);
    checkOutput("s2.c2.valid", 32'(bus.oResultValid), 32'd0);
    @(negedge iCLK);
    applyStimulus(1'b0, OPNONE, 5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0);
    #1; checkOutput("s2.c3.rtUnused", 32'(bus.oStall), 32'd0);
    @(negedge iCLK);
    idleCycle();
    #1; checkOutput("s2.c4.valid", 32'(bus.oResultValid), 32'd0);
    @(negedge iCLK);
    idleCycle();
    #1;
    checkOutput("s2.c5.valid", 32'(bus.oResultValid), 32'd1);
    checkOutput("s2.c5.wbReg", 32'(bus.oWbReg), 32'd3);
    checkOutput("s2.c5.op", 32'(bus.oOp), 32'(OPMULS));
    @(negedge iCLK);
    idleCycle();
    #1; checkOutput("s2.c6.busy", 32'(bus.oBusy), 32'd0);
    @(negedge iCLK);

    $display("[TB] scenario 3: RAW stall on SQRT destination");
    applyStimulus(1'b1, OPSQRT, 5'd15, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge iCLK);
    applyStimulus(1'b0, OPNONE, 5'd0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    #1; checkOutput("s3.c1.noRaw", 32'(bus.oStall), 32'd0);
    @(negedge iCLK);
    applyStimulus(1'b1, OPADDS, 5'd3, 5'd1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    #1; checkOutput("s3.c2.structStall", 32'(bus.oStall), 32'd1);
    @(negedge iCLK);
    for (int c = 3; c <= 16; c++) begin
      applyStimulus(1'b0, OPNONE, 5'd0, 5'd0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("s3.c%0d.stall", c), 32'(bus.oStall), 32'(c <= 15));
      checkOutput($sformatf("s3.c%0d.valid", c), 32'(bus.oResultValid), 32'(c == 15));
      if (c == 15) checkOutput("s3.c15.wbReg", 32'(bus.oWbReg), 32'd8);
      @(negedge iCLK);
    end

    $display("[TB] scenario 4: compare op held by writeback port");
    applyStimulus(1'b1, OPCLT, 5'd1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge iCLK);
    for (int c = 1; c <= 3; c++) begin
      if (c == 2)
        applyStimulus(1'b1, OPADDS, 5'd2, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      else if (c == 3)
        applyStimulus(1'b0, OPNONE, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
      else
        applyStimulus(1'b0, OPNONE, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      #1;
      checkOutput($sformatf("s4.c%0d.busy", c), 32'(bus.oBusy), 32'd1);
      checkOutput($sformatf("s4.c%0d.valid", c), 32'(bus.oResultValid), 32'd0);
      checkOutput($sformatf("s4.c%0d.flagEn", c), 32'(bus.oWbFlagEn), 32'd0);
      checkOutput($sformatf("s4.c%0d.stall", c), 32'(bus.oStall), 32'(c == 2));
      @(negedge iCLK);
    end
    idleCycle();
    #1;
    checkOutput("s4.c4.valid", 32'(bus.oResultValid), 32'd1);
    checkOutput("s4.c4.flagEn", 32'(bus.oWbFlagEn), 32'd1);
    checkOutput("s4.c4.regEn", 32'(bus.oWbRegEn), 32'd0);
    checkOutput("s4.c4.op", 32'(bus.oOp), 32'(OPCLT));
    @(negedge iCLK);
    idleCycle();
    #1; checkOutput("s4.c5.busy", 32'(bus.oBusy), 32'd0);
    @(negedge iCLK);

    $display("[TB] scenario 5: illegal starts");
    applyStimulus(1'b1, OPNONE, 5'd0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("s5.c0.illegal", 32'(bus.oIllegal), 32'd1);
    checkOutput("s5.c0.stall", 32'(bus.oStall), 32'd0);
    @(negedge iCLK);
    applyStimulus(1'b1, OPNONE, 5'd3, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("s5.c1.illegalOp0", 32'(bus.oIllegal), 32'd1);
    checkOutput("s5.c1.busy", 32'(bus.oBusy), 32'd0);
    @(negedge iCLK);
    idleCycle();
    #1;
    checkOutput("s5.c2.illegal", 32'(bus.oIllegal), 32'd0);
    checkOutput("s5.c2.busy", 32'(bus.oBusy), 32'd0);
    @(negedge iCLK);
    applyStimulus(1'b1, OPADDS, 5'd4, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge iCLK);
    applyStimulus(1'b1, OPADDS, 5'd0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("s5.c4.stall", 32'(bus.oStall), 32'd1);
    checkOutput("s5.c4.illegal", 32'(bus.oIllegal), 32'd0);
    @(negedge iCLK);
    for (int c = 5; c <= 8; c++) begin
      idleCycle();
      #1;
      checkOutput($sformatf("s5.c%0d.valid", c), 32'(bus.oResultValid), 32'(c == 7));
      if (c == 7) checkOutput("s5.c7.wbReg", 32'(bus.oWbReg), 32'd7);
      if (c == 8) checkOutput("s5.c8.busy", 32'(bus.oBusy), 32'd0);
      @(negedge iCLK);
    end

    $display("[TB] scenario 6: async reset mid-operation");
    applyStimulus(1'b1, OPDIVS, 5'd5, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge iCLK);
    for (int c = 1; c <= 2; c++) begin
      idleCycle();
      #1; checkOutput($sformatf("s6.c%0d.busy", c), 32'(bus.oBusy), 32'd1);
      @(negedge iCLK);
    end
    idleCycle();
    #2;
    iRST = 1'b1;
    #1;
    checkOutput("s6.rst.busy", 32'(bus.oBusy), 32'd0);
    checkOutput("s6.rst.wbReg", 32'(bus.oWbReg), 32'd0);
    checkOutput("s6.rst.op", 32'(bus.oOp), 32'd0);
    checkOutput("s6.rst.valid", 32'(bus.oResultValid), 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      idleCycle();
      #1;
      checkOutput($sformatf("s6.c%0d.noStrobe", c), 32'(bus.oResultValid), 32'd0);
      checkOutput($sformatf("s6.c%0d.busy", c), 32'(bus.oBusy), 32'd0);
      @(negedge iCLK);
    end
    runAddScenario("s6again");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
